// File: rtl/kf_pkg.sv
// Shared types and helpers for the Kalman-filter datapath blocks.
// Reduction works on a fixed 64-bit container so one function serves every element width.
package kf_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      MUL1,
      MUL2,
      DONE
   } cov_state_t;

   localparam int RED_W = 64;

   typedef struct packed {
      logic signed [RED_W-1:0] value;
      logic                    ovf;
   } reduce_t;

   // Accumulator wide enough that nos products of two WIDTH-bit operands never overflow.
   function automatic int acc_width(input int width, input int n);
      return 2 * width + $clog2(n) + 1;
   endfunction

   function automatic reduce_t sat_reduce(input logic signed [RED_W-1:0] value,
                                          input int                      width,
                                          input logic                    sat);
      reduce_t                 r;
      logic signed [RED_W-1:0] max_v;
      logic signed [RED_W-1:0] min_v;
      logic signed [RED_W-1:0] wrapped;
      max_v   = (64'sd1 <<< (width - 1)) - 64'sd1;
      min_v   = -max_v - 64'sd1;
      wrapped = (value <<< (RED_W - width)) >>> (RED_W - width);
      r.ovf   = (value > max_v) || (value < min_v);
      if (!r.ovf)
         r.value = value;
      else if (sat)
         r.value = (value > max_v) ? max_v : min_v;
      else
         r.value = wrapped;
      return r;
   endfunction

endpackage

// File: rtl/kf_mac.sv
// Signed WIDTH x WIDTH multiply-accumulate; clr together with en restarts the sum at the product.
module kf_mac #(
   parameter int WIDTH = 16,
   parameter int ACC_W = 2 * WIDTH + 3
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    clr,
   input  logic                    en,
   input  logic signed [WIDTH-1:0] a,
   input  logic signed [WIDTH-1:0] b,
   output logic signed [ACC_W-1:0] acc
);

   logic signed [2*WIDTH-1:0] prod;

   assign prod = a * b;

   // NOTE: sequential state is updated with non-blocking assignments only, so every
   // register samples values from before the edge regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         acc <= '0;
      else if (en)
         acc <= clr ? ACC_W'(prod) : acc + ACC_W'(prod);
      else if (clr)
         acc <= '0;
   end

endmodule

// File: rtl/covariance_predictor.sv
// Kalman prediction step P_pred = F*P*F' + Q on one shared MAC: phase MUL1 builds T = F*P,
// phase MUL2 builds T*F' + Q reading F with swapped indices.
module covariance_predictor
   import kf_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int FRAC  = 0,
   parameter int nos   = 4,
   parameter int SAT   = 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic                    clear,
   input  logic signed [WIDTH-1:0] Fdnk [nos][nos],
   input  logic signed [WIDTH-1:0] P    [nos][nos],
   input  logic signed [WIDTH-1:0] Q    [nos][nos],
   output logic signed [WIDTH-1:0] g    [nos][nos],
   output logic                    busy,
   output logic                    done,
   output logic                    ovf
);

   localparam int            ACC_W = acc_width(WIDTH, nos);
   localparam int            IW    = (nos > 1) ? $clog2(nos) : 1;
   localparam logic [IW-1:0] LAST  = IW'(nos - 1);

   typedef logic signed [WIDTH-1:0] word_t;

   cov_state_t state, next_state;

   word_t f_r   [nos][nos];
   word_t p_r   [nos][nos];
   word_t q_r   [nos][nos];
   word_t t_r   [nos][nos];
   word_t res_r [nos][nos];

   logic [IW-1:0] i, j, k;
   logic          wb;
   logic          in_mul;
   logic          last_elem;
   logic          mac_en;
   logic          mac_clr;
   word_t         mac_a;
   word_t         mac_b;

   logic signed [ACC_W-1:0] acc;
   logic signed [ACC_W-1:0] acc_q;
   logic signed [ACC_W-1:0] acc_sum;
   word_t                   wb_val;
   logic                    wb_ovf;

   function automatic word_t reduce_word(input logic signed [ACC_W-1:0] v, output logic o);
      reduce_t r;
      r = sat_reduce(RED_W'(v), WIDTH, SAT != 0);
      o = r.ovf;
      return r.value[WIDTH-1:0];
   endfunction

   assign in_mul    = (state == MUL1) || (state == MUL2);
   assign last_elem = wb && (i == LAST) && (j == LAST);
   assign mac_en    = in_mul && !wb;
   assign mac_clr   = (k == '0);

   kf_mac #(
      .WIDTH (WIDTH),
      .ACC_W (ACC_W)
   ) u_mac (
      .clk   (clk),
      .rst_n (reset),
      .clr   (mac_clr),
      .en    (mac_en),
      .a     (mac_a),
      .b     (mac_b),
      .acc   (acc)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         state <= IDLE;
      else
         state <= next_state;
   end

   // NOTE: every output of a combinational block gets a default first so no path
   // leaves it unassigned and infers a latch.
   always_comb begin
      next_state = state;
      busy       = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE: if (start) next_state = LOAD;
         LOAD: begin
            busy       = 1'b1;
            next_state = MUL1;
         end
         MUL1: begin
            busy = 1'b1;
            if (last_elem) next_state = MUL2;
         end
         MUL2: begin
            busy = 1'b1;
            if (last_elem) next_state = DONE;
         end
         DONE: begin
            done       = 1'b1;
            next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
      if (clear) next_state = IDLE;
   end

   // MUL2 reads F(j,k) in place of F'(k,j), so no transposed copy is kept.
   always_comb begin
      mac_a  = t_r[i][k];
      mac_b  = f_r[j][k];
      acc_q  = '0;
      wb_ovf = 1'b0;
      if (state == MUL1) begin
         mac_a = f_r[i][k];
         mac_b = p_r[k][j];
      end
      if (state == MUL2)
         acc_q = ACC_W'(q_r[i][j]);
      acc_sum = (acc >>> FRAC) + acc_q;
      wb_val  = reduce_word(acc_sum, wb_ovf);
   end

   // NOTE: the operand and result buffers sit on the async reset because a reset must
   // leave no trace of a previous run anywhere in the block.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int a = 0; a < nos; a++) begin
            for (int b = 0; b < nos; b++) begin
               f_r[a][b]   <= '0;
               p_r[a][b]   <= '0;
               q_r[a][b]   <= '0;
               t_r[a][b]   <= '0;
               res_r[a][b] <= '0;
               g[a][b]     <= '0;
            end
         end
         i   <= '0;
         j   <= '0;
         k   <= '0;
         wb  <= 1'b0;
         ovf <= 1'b0;
      end else if (!clear) begin
         case (state)
            LOAD: begin
               f_r <= Fdnk;
               p_r <= P;
               q_r <= Q;
               i   <= '0;
               j   <= '0;
               k   <= '0;
               wb  <= 1'b0;
               ovf <= 1'b0;
            end
            MUL1, MUL2: begin
               if (!wb) begin
                  if (k == LAST)
                     wb <= 1'b1;
                  else
                     k <= k + 1'b1;
               end else begin
                  wb  <= 1'b0;
                  k   <= '0;
                  ovf <= ovf | wb_ovf;
                  if (state == MUL1)
                     t_r[i][j] <= wb_val;
                  else
                     res_r[i][j] <= wb_val;
                  if (j == LAST) begin
                     j <= '0;
                     i <= (i == LAST) ? '0 : i + 1'b1;
                  end else begin
                     j <= j + 1'b1;
                  end
                  // g must already hold the new result during DONE, so the final element
                  // bypasses the buffer.
                  if (state == MUL2 && last_elem) begin
                     for (int a = 0; a < nos; a++)
                        for (int b = 0; b < nos; b++)
                           g[a][b] <= res_r[a][b];
                     g[LAST][LAST] <= wb_val;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_covariance_predictor.sv
// Directed bench for covariance_predictor: a vector table of whole runs on three parameter
// sets, then hand-written handshake, abort and reset sequences.
module tb_covariance_predictor;

   typedef logic signed [15:0] mat_t [4][4];
   typedef int imat_t [4][4];

   typedef struct {
      string name;
      mat_t  f;
      mat_t  p;
      mat_t  q;
      mat_t  exp_g;
      logic  exp_ovf;
      int    sel;
   } vec_t;

   logic clk;
   logic reset;
   logic start;
   logic clear;
   mat_t f_in, p_in, q_in;
   mat_t g0, g1, g2;
   logic busy0, busy1, busy2;
   logic done0, done1, done2;
   logic ovf0, ovf1, ovf2;

   int total;
   int passed;

   covariance_predictor #(.WIDTH(16), .FRAC(0), .nos(4), .SAT(1)) dut0 (
      .clk(clk), .reset(reset), .start(start), .clear(clear),
      .Fdnk(f_in), .P(p_in), .Q(q_in), .g(g0), .busy(busy0), .done(done0), .ovf(ovf0));

   covariance_predictor #(.WIDTH(16), .FRAC(8), .nos(4), .SAT(1)) dut1 (
      .clk(clk), .reset(reset), .start(start), .clear(clear),
      .Fdnk(f_in), .P(p_in), .Q(q_in), .g(g1), .busy(busy1), .done(done1), .ovf(ovf1));

   covariance_predictor #(.WIDTH(16), .FRAC(0), .nos(4), .SAT(0)) dut2 (
      .clk(clk), .reset(reset), .start(start), .clear(clear),
      .Fdnk(f_in), .P(p_in), .Q(q_in), .g(g2), .busy(busy2), .done(done2), .ovf(ovf2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input longint act, input longint exp);
      total++;
      if (act === exp)
         passed++;
      else
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   function automatic mat_t to_mat(input imat_t a);
      mat_t m;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            m[r][c] = 16'(a[r][c]);
      return m;
   endfunction

   function automatic mat_t m_diag(input int v);
      mat_t m;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            m[r][c] = (r == c) ? 16'(v) : 16'sd0;
      return m;
   endfunction

   function automatic mat_t m_fill(input int v);
      mat_t m;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            m[r][c] = 16'(v);
      return m;
   endfunction

   function automatic mat_t m_one(input int v);
      mat_t m;
      m = m_fill(0);
      m[0][0] = 16'(v);
      return m;
   endfunction

   function automatic vec_t mk(input string n, input mat_t f, input mat_t p, input mat_t q,
                               input mat_t eg, input logic eo, input int s);
      vec_t v;
      v.name = n; v.f = f; v.p = p; v.q = q; v.exp_g = eg; v.exp_ovf = eo; v.sel = s;
      return v;
   endfunction

   function automatic int g_of(input int s, input int r, input int c);
      case (s)
         1:       return int'(g1[r][c]);
         2:       return int'(g2[r][c]);
         default: return int'(g0[r][c]);
      endcase
   endfunction

   function automatic logic done_of(input int s);
      case (s)
         1:       return done1;
         2:       return done2;
         default: return done0;
      endcase
   endfunction

   function automatic logic busy_of(input int s);
      case (s)
         1:       return busy1;
         2:       return busy2;
         default: return busy0;
      endcase
   endfunction

   function automatic logic ovf_of(input int s);
      case (s)
         1:       return ovf1;
         2:       return ovf2;
         default: return ovf0;
      endcase
   endfunction

   // Period p is observed at the falling edge after the p-th rising edge following the start edge.
   task automatic run_one(input int s, output int lat, output logic busy_ok);
      int p;
      lat     = -1;
      busy_ok = 1'b1;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      p = 1;
      while (lat < 0 && p <= 400) begin
         if (done_of(s)) begin
            lat = p;
            if (busy_of(s)) busy_ok = 1'b0;
         end else begin
            if (!busy_of(s)) busy_ok = 1'b0;
            @(negedge clk);
            p++;
         end
      end
   endtask

   vec_t tv[8];
   mat_t p0;
   int   lat;
   logic busy_ok;
   int   ndone, d1, d2;

   initial begin
      total  = 0;
      passed = 0;
      reset  = 1'b0;
      start  = 1'b0;
      clear  = 1'b0;
      f_in   = m_fill(0);
      p_in   = m_fill(0);
      q_in   = m_fill(0);

      p0 = to_mat('{'{7, 3, 4, 8}, '{4, 5, 1, 7}, '{8, 8, 7, 2}, '{5, 9, 8, 9}});

      tv[0] = mk("identity", m_diag(1), p0, m_fill(0), p0, 1'b0, 0);
      tv[1] = mk("scale_noise", m_diag(2), p0, m_fill(1),
                 to_mat('{'{29, 13, 17, 33}, '{17, 21, 5, 29}, '{33, 33, 29, 9}, '{21, 37, 33, 37}}),
                 1'b0, 0);
      tv[2] = mk("row_add", to_mat('{'{1, 1, 0, 0}, '{0, 1, 0, 0}, '{0, 0, 1, 0}, '{0, 0, 0, 1}}),
                 p0, m_fill(0),
                 to_mat('{'{19, 8, 5, 15}, '{9, 5, 1, 7}, '{16, 8, 7, 2}, '{14, 9, 8, 9}}),
                 1'b0, 0);
      tv[3] = mk("neg_ident_negq", m_diag(-1), p0, m_fill(-3),
                 to_mat('{'{4, 0, 1, 5}, '{1, 2, -2, 4}, '{5, 5, 4, -1}, '{2, 6, 5, 6}}),
                 1'b0, 0);
      tv[4] = mk("fx_identity", m_diag(256), m_one(16'h0180), m_fill(0), m_one(16'h0180), 1'b0, 1);
      tv[5] = mk("fx_half", m_diag(128), m_one(16'h0180), m_fill(0), m_one(16'h0060), 1'b0, 1);
      tv[6] = mk("ovf_sat", m_diag(200), m_one(100), m_fill(0), m_one(32767), 1'b1, 0);
      tv[7] = mk("ovf_wrap", m_diag(200), m_one(100), m_fill(0), m_one(2304), 1'b1, 2);

      repeat (2) @(negedge clk);
      check("rst_g00", g0[0][0], 0);
      check("rst_busy", busy0, 0);
      check("rst_done", done0, 0);
      check("rst_ovf", ovf0, 0);
      reset = 1'b1;

      for (int v = 0; v < 8; v++) begin
         f_in = tv[v].f;
         p_in = tv[v].p;
         q_in = tv[v].q;
         run_one(tv[v].sel, lat, busy_ok);
         check({tv[v].name, "_latency"}, lat, 162);
         check({tv[v].name, "_busy"}, busy_ok, 1);
         check({tv[v].name, "_ovf"}, ovf_of(tv[v].sel), tv[v].exp_ovf);
         for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
               check($sformatf("%s_g%0d%0d", tv[v].name, r, c), g_of(tv[v].sel, r, c),
                     int'(tv[v].exp_g[r][c]));
      end

      // Held start, stray start in MUL2, start held across DONE into the following IDLE cycle.
      f_in = m_diag(1);
      p_in = p0;
      q_in = m_fill(0);
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      ndone = 0;
      d1    = -1;
      d2    = -1;
      for (int p = 1; p <= 400; p++) begin
         @(negedge clk);
         if (done0) begin
            ndone++;
            if (d1 < 0) d1 = p;
            else if (d2 < 0) d2 = p;
         end
         if (p == 1 || p == 161 || p == 164) check($sformatf("hs_busy_p%0d", p), busy0, 1);
         if (p == 162 || p == 163) check($sformatf("hs_busy_p%0d", p), busy0, 0);
         start = (p < 20) || (p == 100) || (p == 162) || (p == 163);
      end
      start = 1'b0;
      check("hs_done_count", ndone, 2);
      check("hs_first_done", d1, 162);
      check("hs_second_done", d2, 325);
      check("hs_g12", g0[1][2], 1);

      // Abort mid-MUL1 with clear; the previous result and flag must survive.
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      ndone = 0;
      for (int p = 1; p <= 250; p++) begin
         @(negedge clk);
         start = 1'b0;
         if (done0) ndone++;
         if (p == 50) check("clr_busy_before", busy0, 1);
         if (p == 51) check("clr_idle", busy0, 0);
         clear = (p == 50);
      end
      check("clr_no_done", ndone, 0);
      check("clr_g00", g0[0][0], 7);
      check("clr_g33", g0[3][3], 9);
      check("clr_ovf", ovf0, 0);

      // Reset mid-run after a MUL1 overflow has set the sticky flag.
      f_in = m_diag(300);
      p_in = m_one(200);
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (99) @(negedge clk);
      check("mid_ovf", ovf0, 1);
      check("mid_g_held", g0[0][0], 7);
      reset = 1'b0;
      #1;
      check("arst_g00", g0[0][0], 0);
      check("arst_g23", g0[2][3], 0);
      check("arst_busy", busy0, 0);
      check("arst_done", done0, 0);
      check("arst_ovf", ovf0, 0);
      @(negedge clk);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      check("post_rst_idle", busy0, 0);

      f_in = m_diag(1);
      p_in = p0;
      run_one(0, lat, busy_ok);
      check("recover_latency", lat, 162);
      check("recover_g21", g0[2][1], 8);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
